// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritised write ports, same-cycle
// write-to-read bypass, per-register pending-write scoreboard, post-reset zero sweep.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr
);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREG];

  logic              run;
  logic              wr0_ok, wr1_ok, sb_ok;
  logic [AW-1:0]     ra;
  logic              hit0, hit1;

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign wr0_ok    = run && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_ok    = run && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
  assign sb_ok     = run && sb_set_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(NREG - 1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array has no reset so it can map onto RAM; the sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[idx_q] <= '0;
      end else begin
        if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
        if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int unsigned a = 0; a < NREG; a++) begin
      if ((wr0_ok && wr0_addr == AW'(a)) || (wr1_ok && wr1_addr == AW'(a)))
        busy_d[a] = 1'b0;
      if (sb_ok && sb_set_addr == AW'(a))
        busy_d[a] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    if (run) begin
      for (int unsigned p = 0; p < NRD; p++) begin
        ra   = rd_addr[p*AW +: AW];
        hit1 = (BYPASS != 0) && wr1_ok && (wr1_addr == ra);
        hit0 = (BYPASS != 0) && wr0_ok && (wr0_addr == ra);
        if (!((ZERO_REG != 0) && (ra == '0))) begin
          if (hit1)      rd_data[p*XLEN +: XLEN] = wr1_data;
          else if (hit0) rd_data[p*XLEN +: XLEN] = wr0_data;
          else           rd_data[p*XLEN +: XLEN] = mem_q[ra];
          rd_busy[p] = busy_q[ra] & ~(hit0 | hit1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed vectors push expectations, a
// negedge monitor pops and compares. A BYPASS=0 twin shares all inputs.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr0_en, wr1_en, sb_set_en;
  logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        init_done, init_nb;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .init_done(init_nb),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
  );

  typedef struct {
    string       nm;
    int unsigned tag;
    logic        xi;
    logic [31:0] x0, x1;
    logic [1:0]  xb;
    logic        cnb;
    logic [31:0] xnb;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc_n = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].tag == cyc_n) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (init_done !== e.xi) begin
        n_err++; $display("FAIL %s init_done got %b want %b", e.nm, init_done, e.xi);
      end
      if (init_nb !== e.xi) begin
        n_err++; $display("FAIL %s nb.init_done got %b want %b", e.nm, init_nb, e.xi);
      end
      if (rd_data[31:0] !== e.x0) begin
        n_err++; $display("FAIL %s rd_data0 got %h want %h", e.nm, rd_data[31:0], e.x0);
      end
      if (rd_data[63:32] !== e.x1) begin
        n_err++; $display("FAIL %s rd_data1 got %h want %h", e.nm, rd_data[63:32], e.x1);
      end
      if (rd_busy !== e.xb) begin
        n_err++; $display("FAIL %s rd_busy got %b want %b", e.nm, rd_busy, e.xb);
      end
      if (e.cnb && rd_data_nb[31:0] !== e.xnb) begin
        n_err++; $display("FAIL %s nb.rd_data0 got %h want %h", e.nm, rd_data_nb[31:0], e.xnb);
      end
    end
  end

  task automatic vec(input string nm, input logic rst,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic e0, input logic [4:0] ad0, input logic [31:0] dt0,
                     input logic e1, input logic [4:0] ad1, input logic [31:0] dt1,
                     input logic se, input logic [4:0] sa,
                     input logic xi, input logic [31:0] x0, input logic [31:0] x1,
                     input logic [1:0] xb, input logic cnb, input logic [31:0] xnb);
    exp_t e;
    reset = rst; rd_addr = {a1, a0};
    wr0_en = e0; wr0_addr = ad0; wr0_data = dt0;
    wr1_en = e1; wr1_addr = ad1; wr1_data = dt1;
    sb_set_en = se; sb_set_addr = sa;
    e.nm = nm; e.tag = cyc_n; e.xi = xi; e.x0 = x0; e.x1 = x1;
    e.xb = xb; e.cnb = cnb; e.xnb = xnb;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    @(posedge clk); #1;

    vec("rst", 1, 5'd5, 5'd6, 0,0,0, 0,0,0, 0,0, 0, 0, 0, 2'b00, 1, 0);

    // First sweep; writes and a scoreboard set land mid-sweep and must be ignored.
    for (int k = 0; k < 32; k++) begin
      if (k == 20)
        vec("clr_wr", 0, 5'd3, 5'd4, 1,5'd3,32'hAAAA5555, 1,5'd4,32'h12345678, 1,5'd6,
            0, 0, 0, 2'b00, 1, 0);
      else
        vec("sweep1", 0, 5'(k), 5'd31, 0,0,0, 0,0,0, 0,0, 0, 0, 0, 2'b00, 1, 0);
    end
    vec("clr_rd34", 0, 5'd3, 5'd4, 0,0,0, 0,0,0, 0,0, 1, 0, 0, 2'b00, 1, 0);
    vec("clr_sb6",  0, 5'd6, 5'd6, 0,0,0, 0,0,0, 0,0, 1, 0, 0, 2'b00, 1, 0);

    // Fill every register with a nonzero value; port0 sees it via bypass.
    for (int i = 1; i < 32; i++)
      vec("fill", 0, 5'(i), 5'(i-1), 1,5'(i),32'h100+32'(i), 0,0,0, 0,0,
          1, 32'h100+32'(i), (i == 1) ? 32'h0 : 32'h100+32'(i-1), 2'b00, 1, 0);

    vec("rst2_pre", 1, 5'd5, 5'd5, 0,0,0, 0,0,0, 0,0, 1, 32'h105, 32'h105, 2'b00, 1, 32'h105);
    for (int k = 0; k < 10; k++)
      vec("sweep2", 0, 5'd5, 5'd31, 0,0,0, 0,0,0, 0,0, 0, 0, 0, 2'b00, 1, 0);
    vec("rst_mid", 1, 5'd5, 5'd31, 0,0,0, 0,0,0, 0,0, 0, 0, 0, 2'b00, 1, 0);
    for (int k = 0; k < 32; k++)
      vec("sweep3", 0, 5'd5, 5'd31, 0,0,0, 0,0,0, 0,0, 0, 0, 0, 2'b00, 1, 0);
    for (int i = 0; i < 32; i++)
      vec("zeroed", 0, 5'(i), 5'(31-i), 0,0,0, 0,0,0, 0,0, 1, 0, 0, 2'b00, 1, 0);

    vec("byp_wr0",   0, 5'd5, 5'd5, 1,5'd5,32'hDEADBEEF, 0,0,0, 0,0,
        1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'h0);
    vec("byp_after", 0, 5'd5, 5'd5, 0,0,0, 0,0,0, 0,0,
        1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'hDEADBEEF);

    vec("prio_same", 0, 5'd7, 5'd5, 1,5'd7,32'h11111111, 1,5'd7,32'h22222222, 0,0,
        1, 32'h22222222, 32'hDEADBEEF, 2'b00, 1, 32'h0);
    vec("prio_after", 0, 5'd7, 5'd7, 0,0,0, 0,0,0, 0,0,
        1, 32'h22222222, 32'h22222222, 2'b00, 1, 32'h22222222);

    vec("r0_wr",    0, 5'd0, 5'd0, 1,5'd0,32'hFFFFFFFF, 1,5'd0,32'hFFFFFFFF, 1,5'd0,
        1, 0, 0, 2'b00, 1, 0);
    vec("r0_after", 0, 5'd0, 5'd0, 0,0,0, 0,0,0, 0,0, 1, 0, 0, 2'b00, 1, 0);

    vec("sb_set9",   0, 5'd9, 5'd9, 0,0,0, 0,0,0, 1,5'd9, 1, 0, 0, 2'b00, 1, 0);
    vec("sb_busy9",  0, 5'd9, 5'd9, 0,0,0, 0,0,0, 0,0, 1, 0, 0, 2'b11, 1, 0);
    vec("sb_split",  0, 5'd9, 5'd5, 0,0,0, 0,0,0, 0,0, 1, 0, 32'hDEADBEEF, 2'b01, 1, 0);
    vec("sb_wr1_9",  0, 5'd9, 5'd9, 0,0,0, 1,5'd9,32'h5, 0,0, 1, 32'h5, 32'h5, 2'b00, 1, 0);
    vec("sb_clr9",   0, 5'd9, 5'd9, 0,0,0, 0,0,0, 0,0, 1, 32'h5, 32'h5, 2'b00, 1, 32'h5);
    vec("sb_setwr9", 0, 5'd9, 5'd9, 1,5'd9,32'h77, 0,0,0, 1,5'd9,
        1, 32'h77, 32'h77, 2'b00, 1, 32'h5);
    vec("sb_win9",   0, 5'd9, 5'd9, 0,0,0, 0,0,0, 0,0, 1, 32'h77, 32'h77, 2'b11, 1, 32'h77);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the CPU datapath: configurable width, depth and read-port count, two write ports with defined priority, same-cycle write-to-read bypass and a per-register pending-write scoreboard. Contents are zeroed by a hardware sweep after reset instead of a single-cycle bulk clear, so the array maps onto RAM primitives. It sits between decode (read ports, scoreboard set) and writeback (two write ports: ALU and load/long-latency unit).

## Interface
- XLEN, 32, register width in bits
- NREG, 32, number of registers (power of two, >= 2)
- AW, 5, address width, must equal log2(NREG)
- NRD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- init_done  out  1  high once the clear sweep has finished; writes and scoreboard sets are accepted only while high
- rd_addr  in  NRD*AW  read addresses, port p at bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN], combinational
- rd_busy  out  NRD  per-port pending-write flag, combinational
- wr0_en / wr0_addr / wr0_data  in  1 / AW / XLEN  write port 0
- wr1_en / wr1_addr / wr1_data  in  1 / AW / XLEN  write port 1 (higher priority)
- sb_set_en / sb_set_addr  in  1 / AW  mark register as having an in-flight producer

## Operation
- FSM states: CLEAR, RUN.
- reset high: state <= CLEAR, sweep index <= 0, all busy bits <= 0. reset overrides everything, including mid-sweep (sweep restarts at 0) and in RUN.
- CLEAR, reset low: each edge writes 0 to reg[idx], idx <= idx+1; after writing idx = NREG-1, state <= RUN. wr0/wr1/sb_set ignored. rd_data all 0, rd_busy all 0, init_done 0.
- RUN: init_done 1.
  - Write: wrN_en writes wrN_data to reg[wrN_addr] at the edge. Both ports same address: wr1 data stored. ZERO_REG=1 and addr 0: write dropped.
  - Read port p: ZERO_REG=1 and addr 0 -> 0. Else if BYPASS=1 and wr1_en and wr1_addr matches -> wr1_data; else if BYPASS=1 and wr0_en and wr0_addr matches -> wr0_data; else reg[addr]. BYPASS=0: array only (new value visible the cycle after the write).
  - Scoreboard: busy[a] <= 1 on sb_set_en for a; busy[a] <= 0 on any write to a. Same-cycle set and write to same a: set wins (busy stays 1). ZERO_REG=1: busy[0] always 0.
  - rd_busy[p] = busy[rd_addr p], masked to 0 when BYPASS=1 and a same-cycle write targets that address (data being forwarded).
- Scoreboard set for an already-busy register is legal and leaves it busy (no count).

## Timing
- Reset values: init_done 0, rd_data 0 on all ports, rd_busy 0, all busy bits 0; array contents 0 after sweep.
- init_done rises exactly NREG rising edges after the first edge with reset low.
- Read latency 0 (combinational from address); write latency 1 edge to array.
- Bypass path combinational from wr*_en/addr/data to rd_data/rd_busy.
- sb_set visible on rd_busy the cycle after the set edge.

## Test plan
- Reset 1 cycle, release; preload by backdoor nonzero values before reset -> init_done low for exactly 32 cycles, all reads 0 during sweep, every register reads 0 after; reassert reset at sweep idx 10 -> sweep restarts, init_done delayed a further 32 cycles.
- RUN: wr0 reg5=0xDEADBEEF with rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF same cycle (BYPASS=1); next cycle still 0xDEADBEEF; with BYPASS=0 old value 0 same cycle, new value next cycle.
- Simultaneous wr0 reg7=0x11111111, wr1 reg7=0x22222222 -> forwarded and stored value 0x22222222.
- Write reg0=0xFFFFFFFF via both ports, sb_set reg0 -> rd_data 0, rd_busy 0 on all ports.
- sb_set reg9 -> rd_busy=1 next cycle; wr1 reg9=0x5 -> rd_busy 0 same cycle (forwarded), busy clear after edge; sb_set reg9 with wr0 reg9 same cycle -> busy remains 1.
- Writes and sb_set issued during CLEAR -> no effect; after init_done target registers read 0, not busy.
